// File: rtl/multi_cycle_chunk_adder_if.sv
// multi_cycle_chunk_adder_if: operand/result handshake bundle for multi_cycle_chunk_adder.
// The sub signal exists only when MCCA_SUB_EN is defined.
interface multi_cycle_chunk_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             res_ready;
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef MCCA_SUB_EN
    logic             sub;
    modport master(output start, a, b, cin, sub, res_ready, input ready, valid, sum, cout, ovf);
    modport slave(input start, a, b, cin, sub, res_ready, output ready, valid, sum, cout, ovf);
`else
    modport master(output start, a, b, cin, res_ready, input ready, valid, sum, cout, ovf);
    modport slave(input start, a, b, cin, res_ready, output ready, valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/multi_cycle_chunk_adder.sv
// multi_cycle_chunk_adder: WIDTH-bit A+B+cin computed CHUNK_WIDTH bits per clock via a registered carry.
// Defining MCCA_SUB_EN adds the sub input, turning the operation into A-B-cin (borrow-in).
module multi_cycle_chunk_adder #(
    parameter int WIDTH       = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    multi_cycle_chunk_adder_if.slave bus
);
    localparam int NUM_CHUNKS = WIDTH / CHUNK_WIDTH;
    localparam int KW         = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;

    if (CHUNK_WIDTH < 1 || WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
        $error("CHUNK_WIDTH must divide WIDTH exactly");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_n;
    logic [WIDTH-1:0]       a_r, b_r, acc, acc_n, sum_r;
    logic [CHUNK_WIDTH-1:0] a_k, b_k, s;
    logic [KW-1:0]          k;
    logic                   carry, c, cout_r, ovf_r, last, accept;

    assign accept = state == IDLE && bus.start;
    assign last   = k == KW'(NUM_CHUNKS - 1);

    always_comb begin
        a_k     = a_r[k*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_k     = b_r[k*CHUNK_WIDTH +: CHUNK_WIDTH];
        {c, s}  = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK_WIDTH{1'b0}}, carry};
        acc_n   = acc;
        acc_n[k*CHUNK_WIDTH +: CHUNK_WIDTH] = s;
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (bus.start ? BUSY : IDLE)
                : state == BUSY ? (last ? DONE : BUSY)
                : (bus.res_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // acc collects the result chunk by chunk; sum_r only updates on the final chunk so
    // the visible result stays at the previous value for the whole operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            k      <= '0;
        end else if (accept) begin
            a_r   <= bus.a;
`ifdef MCCA_SUB_EN
            b_r   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.cin ^ bus.sub;
`else
            b_r   <= bus.b;
            carry <= bus.cin;
`endif
            k     <= '0;
        end else if (state == BUSY) begin
            acc   <= acc_n;
            carry <= c;
            k     <= k + KW'(1);
            if (last) begin
                sum_r  <= acc_n;
                cout_r <= c;
                ovf_r  <= c ^ a_k[CHUNK_WIDTH-1] ^ b_k[CHUNK_WIDTH-1] ^ s[CHUNK_WIDTH-1];
            end
        end
    end

    assign bus.ready = state == IDLE;
    assign bus.valid = state == DONE;
    assign bus.sum   = sum_r;
    assign bus.cout  = cout_r;
    assign bus.ovf   = ovf_r;
endmodule
